multicycle_main_control: RTL and testbench

- Main control FSM of the multi-cycle RV32I core; sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback and drives the datapath strobes and mux selects.
- Drives alu_op and is_imm, which the ALU control decoder consumes.
- Stalls on a memory ready handshake; traps on illegal opcodes.

---
 rtl/multicycle_main_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives datapath strobes, mux selects and ALU-decoder hints.
module multicycle_main_control #(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [1:0] alu_op,
  output logic       is_imm,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JUMP, S_JALRADR,
    S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam state_t RESET_STATE = (RESET_STATE_FETCH != 0) ? S_FETCH : S_FETCH;

  state_t state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RESET_STATE;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_R:              state <= S_EXECR;
            OP_I:              state <= S_EXECI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JUMP;
            OP_JALR:           state <= S_JALRADR;
            OP_LUI:            state <= S_LUI;
            OP_AUIPC:          state <= S_AUIPC;
            default:           state <= S_TRAP;
          endcase
        end
        S_MEMADR:   state <= (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR, S_EXECI, S_LUI, S_AUIPC: state <= S_ALUWB;
        S_JALRADR:  state <= S_JUMP;
        S_JUMP:     state <= S_ALUWB;
        S_ALUWB, S_BRANCH: state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from state combinationally: FETCH must gate ir/pc writes with
  // mem_ready and a low resetn must kill every strobe in the same cycle.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = 3'b000;
    alu_op     = 2'b00;
    is_imm     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        is_imm    = 1'b1;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
      end
      S_JALRADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_JUMP: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_TRAP:   illegal = 1'b1;
      default:  ;
    endcase
    if (!resetn) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      imm_src    = 3'b000;
      alu_op     = 2'b00;
      is_imm     = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench: each instruction expands into a list of expected per-cycle
// output vectors; a monitor on the falling edge compares them with the DUT.
module tb_multicycle_main_control;

  typedef logic [19:0] vec_t;
  // Field order: req,wr,adr,ir,pc,br,rw | src_a | src_b | result_src | imm_src | alu_op | is_imm,illegal
  localparam vec_t V_FETCH_GO    = {7'b1001100, 2'b00, 2'b10, 2'b10, 3'b000, 2'b00, 2'b00};
  localparam vec_t V_FETCH_STALL = {7'b1000000, 2'b00, 2'b10, 2'b10, 3'b000, 2'b00, 2'b00};
  localparam vec_t V_MEMADR_L    = {7'b0000000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam vec_t V_MEMADR_S    = {7'b0000000, 2'b10, 2'b01, 2'b00, 3'b001, 2'b00, 2'b00};
  localparam vec_t V_MEMREAD     = {7'b1010000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam vec_t V_MEMWB       = {7'b0000001, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00, 2'b00};
  localparam vec_t V_MEMWRITE    = {7'b1110000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam vec_t V_EXECR       = {7'b0000000, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 2'b00};
  localparam vec_t V_EXECI       = {7'b0000000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b11, 2'b10};
  localparam vec_t V_LUI         = {7'b0000000, 2'b11, 2'b01, 2'b00, 3'b100, 2'b00, 2'b00};
  localparam vec_t V_AUIPC       = {7'b0000000, 2'b01, 2'b01, 2'b00, 3'b100, 2'b00, 2'b00};
  localparam vec_t V_JALRADR     = {7'b0000000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam vec_t V_JUMP        = {7'b0000100, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam vec_t V_ALUWB       = {7'b0000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam vec_t V_BRANCH      = {7'b0000010, 2'b10, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00};
  localparam vec_t V_TRAP        = {7'b0000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01};

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // kind: 0 = one cycle, 1 = held until mem_ready, 2 = held until reset
  typedef struct {
    vec_t go;
    vec_t stall;
    int   kind;
    int   wait_cycles;
  } step_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, branch, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [2:0] imm_src;
  logic       is_imm, illegal;

  multicycle_main_control #(.RESET_STATE_FETCH(1)) dut (
    .clk(clk), .resetn(resetn), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .alu_op(alu_op),
    .is_imm(is_imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  vec_t obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, branch, reg_write,
                alu_src_a, alu_src_b, result_src, imm_src, alu_op, is_imm, illegal};

  vec_t       sb[$];
  step_t      script[$];
  logic [6:0] cur_op = '0;
  int         trap_cycles = 0;
  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;

  logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD,
                                OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};

  function automatic step_t one(input vec_t v);
    step_t s;
    s = '{go: v, stall: v, kind: 0, wait_cycles: 0};
    return s;
  endfunction

  function automatic step_t held(input vec_t g, input vec_t st, input int n);
    step_t s;
    s = '{go: g, stall: st, kind: 1, wait_cycles: n};
    return s;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
                      OP_BRANCH, OP_JAL, OP_JALR};
  endfunction

  task automatic load_script(input logic [6:0] op, input int fs, input int ms);
    vec_t dec;
    dec = {7'b0000000, 2'b01, 2'b01, 2'b00, (op == OP_JAL) ? 3'b011 : 3'b010, 2'b00, 2'b00};
    cur_op = op;
    script.push_back(held(V_FETCH_GO, V_FETCH_STALL, fs));
    script.push_back(one(dec));
    case (op)
      OP_LOAD: begin
        script.push_back(one(V_MEMADR_L));
        script.push_back(held(V_MEMREAD, V_MEMREAD, ms));
        script.push_back(one(V_MEMWB));
      end
      OP_STORE: begin
        script.push_back(one(V_MEMADR_S));
        script.push_back(held(V_MEMWRITE, V_MEMWRITE, ms));
      end
      OP_R:      begin script.push_back(one(V_EXECR)); script.push_back(one(V_ALUWB)); end
      OP_I:      begin script.push_back(one(V_EXECI)); script.push_back(one(V_ALUWB)); end
      OP_LUI:    begin script.push_back(one(V_LUI));   script.push_back(one(V_ALUWB)); end
      OP_AUIPC:  begin script.push_back(one(V_AUIPC)); script.push_back(one(V_ALUWB)); end
      OP_BRANCH: script.push_back(one(V_BRANCH));
      OP_JAL:    begin script.push_back(one(V_JUMP));  script.push_back(one(V_ALUWB)); end
      OP_JALR: begin
        script.push_back(one(V_JALRADR));
        script.push_back(one(V_JUMP));
        script.push_back(one(V_ALUWB));
      end
      default: script.push_back('{go: V_TRAP, stall: V_TRAP, kind: 2, wait_cycles: 0});
    endcase
  endtask

  // One clock of stimulus: choose inputs, advance the reference, queue the expectation.
  task automatic cycle(input bit force_rst, input bit allow_mw_rst);
    logic r, mr;
    vec_t e;
    @(posedge clk);
    #1;
    r  = 1'b1;
    mr = 1'($urandom_range(0, 1));
    if (force_rst) r = 1'b0;
    else if (script.size() > 0 && script[0].kind == 2) begin
      if (trap_cycles >= 10) r = 1'b0;
      else trap_cycles++;
    end
    if (r && script.size() > 0 && script[0].kind == 1) begin
      mr = (script[0].wait_cycles == 0);
      if (allow_mw_rst && script[0].go == V_MEMWRITE && $urandom_range(0, 3) == 0) begin
        r  = 1'b0;
        mr = 1'b0;
      end
    end
    resetn    = r;
    mem_ready = mr;
    opcode    = r ? cur_op : 7'($urandom);
    if (!r || script.size() == 0) begin
      e = '0;
      script.delete();
      trap_cycles = 0;
    end else begin
      e = script[0].go;
      if (script[0].kind == 0) void'(script.pop_front());
      else if (script[0].kind == 1) begin
        if (mr) void'(script.pop_front());
        else begin
          e = script[0].stall;
          script[0].wait_cycles = script[0].wait_cycles - 1;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input bit mw_rst);
    load_script(op, fs, ms);
    while (script.size() > 0) cycle(1'b0, mw_rst);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL out_vec cycle %0d: actual %05h required %05h", cyc, obs, e);
      end
    end
  end

  logic [6:0] dir_op [12] = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
                              OP_BRANCH, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, 7'b0000000};
  int dir_fs [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
  int dir_ms [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0};

  initial begin
    logic [6:0] op;
    repeat (3) cycle(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) run_instr(dir_op[i], dir_fs[i], dir_ms[i], 1'b0);
    // Directed reset while a store waits for memory.
    load_script(OP_STORE, 0, 5);
    repeat (4) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        do op = 7'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
